// File: rtl/cpu_pkg.sv
// Shared definitions for the single-cycle load/store CPU: instruction field
// positions, opcode values and the ALU operation set.
package cpu_pkg;

  localparam int unsigned OP_MSB  = 31;
  localparam int unsigned OP_LSB  = 26;
  localparam int unsigned RD_MSB  = 25;
  localparam int unsigned RD_LSB  = 23;
  localparam int unsigned RS_MSB  = 22;
  localparam int unsigned RS_LSB  = 20;
  localparam int unsigned RT_MSB  = 19;
  localparam int unsigned RT_LSB  = 17;
  localparam int unsigned IMM_MSB = 15;
  localparam int unsigned IMM_LSB = 0;

  localparam logic [5:0] OP_NOP  = 6'h00;
  localparam logic [5:0] OP_ADD  = 6'h01;
  localparam logic [5:0] OP_SUB  = 6'h02;
  localparam logic [5:0] OP_AND  = 6'h03;
  localparam logic [5:0] OP_OR   = 6'h04;
  localparam logic [5:0] OP_XOR  = 6'h05;
  localparam logic [5:0] OP_SLT  = 6'h06;
  localparam logic [5:0] OP_SLL  = 6'h07;
  localparam logic [5:0] OP_SRL  = 6'h08;
  localparam logic [5:0] OP_MUL  = 6'h09;
  localparam logic [5:0] OP_ADDI = 6'h10;
  localparam logic [5:0] OP_LUI  = 6'h11;
  localparam logic [5:0] OP_ORI  = 6'h12;
  localparam logic [5:0] OP_LD   = 6'h18;
  localparam logic [5:0] OP_ST   = 6'h19;
  localparam logic [5:0] OP_BEQ  = 6'h20;
  localparam logic [5:0] OP_BNE  = 6'h21;
  localparam logic [5:0] OP_JMP  = 6'h22;
  localparam logic [5:0] OP_HALT = 6'h3F;

  typedef enum logic [3:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_SLL,
    ALU_SRL,
    ALU_MUL,
    ALU_PASSB
  } alu_op_t;

endpackage

// File: rtl/cpu_alu.sv
// Combinational 32-bit ALU. The multiplier exists only when MUL_EN is defined.
module cpu_alu
  import cpu_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  alu_op_t     alu_op,
  output logic [31:0] result
);

  always_comb begin
    result = '0;
    case (alu_op)
      ALU_ADD:   result = a + b;
      ALU_SUB:   result = a - b;
      ALU_AND:   result = a & b;
      ALU_OR:    result = a | b;
      ALU_XOR:   result = a ^ b;
      ALU_SLT:   result = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      ALU_SLL:   result = a << b[4:0];
      ALU_SRL:   result = a >> b[4:0];
`ifdef MUL_EN
      ALU_MUL:   result = a * b;
`endif
      ALU_PASSB: result = b;
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/cpu_core.sv
// Single-cycle 32-bit load/store CPU: 8x32 register file, instruction ROM, data RAM.
// Define MUL_EN to decode opcode 0x09 as MUL; otherwise it executes as NOP.
module cpu_core
  import cpu_pkg::*;
#(
  parameter int unsigned IMEM_AW   = 8,
  parameter int unsigned DMEM_AW   = 8,
  parameter              IMEM_INIT = "program.hex"
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] rf0,
  output logic [31:0] rf1,
  output logic [31:0] rf2,
  output logic [31:0] rf3,
  output logic [31:0] rf4,
  output logic [31:0] rf5,
  output logic [31:0] rf6,
  output logic [31:0] rf7
);

  logic [31:0] imem [2**IMEM_AW];
  logic [31:0] dmem [2**DMEM_AW];
  logic [31:0] regs [8];

  logic [IMEM_AW-1:0] pc;
  logic [IMEM_AW-1:0] pc_next;
  logic               halted;

  logic [31:0] instr;
  logic [5:0]  op;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [2:0]  rt;
  logic [15:0] imm;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        unused_bit;

  alu_op_t     alu_op;
  logic [31:0] alu_b;
  logic [31:0] alu_result;
  logic        rf_we;
  logic        wb_mem;
  logic        mem_we;
  logic        halt_set;
  logic [DMEM_AW-1:0] daddr;
  logic [31:0] wb_data;

  assign instr      = imem[pc];
  assign op         = instr[OP_MSB:OP_LSB];
  assign rd         = instr[RD_MSB:RD_LSB];
  assign rs         = instr[RS_MSB:RS_LSB];
  assign rt         = instr[RT_MSB:RT_LSB];
  assign imm        = instr[IMM_MSB:IMM_LSB];
  assign unused_bit = instr[16];
  assign sext       = {{16{imm[15]}}, imm};
  assign zext       = {16'h0000, imm};
  assign rs_val     = regs[rs];
  assign rt_val     = regs[rt];

  always_comb begin
    alu_op   = ALU_ADD;
    alu_b    = rt_val;
    rf_we    = 1'b0;
    wb_mem   = 1'b0;
    mem_we   = 1'b0;
    halt_set = 1'b0;
    pc_next  = pc + IMEM_AW'(1);
    case (op)
      OP_ADD:  begin alu_op = ALU_ADD; rf_we = 1'b1; end
      OP_SUB:  begin alu_op = ALU_SUB; rf_we = 1'b1; end
      OP_AND:  begin alu_op = ALU_AND; rf_we = 1'b1; end
      OP_OR:   begin alu_op = ALU_OR;  rf_we = 1'b1; end
      OP_XOR:  begin alu_op = ALU_XOR; rf_we = 1'b1; end
      OP_SLT:  begin alu_op = ALU_SLT; rf_we = 1'b1; end
      OP_SLL:  begin alu_op = ALU_SLL; rf_we = 1'b1; end
      OP_SRL:  begin alu_op = ALU_SRL; rf_we = 1'b1; end
`ifdef MUL_EN
      OP_MUL:  begin alu_op = ALU_MUL; rf_we = 1'b1; end
`endif
      OP_ADDI: begin alu_b = sext; rf_we = 1'b1; end
      OP_LUI:  begin alu_op = ALU_PASSB; alu_b = {imm, 16'h0000}; rf_we = 1'b1; end
      OP_ORI:  begin alu_op = ALU_OR; alu_b = zext; rf_we = 1'b1; end
      OP_LD:   begin alu_b = sext; rf_we = 1'b1; wb_mem = 1'b1; end
      OP_ST:   begin alu_b = sext; mem_we = 1'b1; end
      OP_BEQ:  if (rs_val == rt_val) pc_next = pc + IMEM_AW'(1) + IMEM_AW'(sext);
      OP_BNE:  if (rs_val != rt_val) pc_next = pc + IMEM_AW'(1) + IMEM_AW'(sext);
      OP_JMP:  pc_next = IMEM_AW'(imm);
      OP_HALT: begin halt_set = 1'b1; pc_next = pc; end
      default: ;
    endcase
  end

  cpu_alu u_alu (
    .a      (rs_val),
    .b      (alu_b),
    .alu_op (alu_op),
    .result (alu_result)
  );

  // Effective address keeps only the low DMEM_AW bits, so addresses wrap.
  assign daddr   = DMEM_AW'(alu_result);
  assign wb_data = wb_mem ? dmem[daddr] : alu_result;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc     <= '0;
      halted <= 1'b0;
      for (int unsigned i = 0; i < 8; i++) regs[i] <= '0;
    end else if (!halted) begin
      pc <= pc_next;
      if (halt_set) halted <= 1'b1;
      if (rf_we) regs[rd] <= wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !halted && mem_we) dmem[daddr] <= rt_val;
  end

  assign rf0 = regs[0];
  assign rf1 = regs[1];
  assign rf2 = regs[2];
  assign rf3 = regs[3];
  assign rf4 = regs[4];
  assign rf5 = regs[5];
  assign rf6 = regs[6];
  assign rf7 = regs[7];

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed programs plus random programs run
// against an instruction-level reference model.
module tb_cpu_core;

  localparam int unsigned IDEPTH = 256;
  localparam int unsigned DDEPTH = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [31:0] rf0, rf1, rf2, rf3, rf4, rf5, rf6, rf7;
  logic [31:0] rf [8];

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] prog   [IDEPTH];
  logic [31:0] mregs  [8];
  logic [31:0] mdmem  [DDEPTH];
  logic [7:0]  mpc;
  logic        mhalted;

  cpu_core #(
    .IMEM_AW   (8),
    .DMEM_AW   (8),
    .IMEM_INIT ("program.hex")
  ) dut (
    .clk (clk),
    .rst (rst),
    .rf0 (rf0),
    .rf1 (rf1),
    .rf2 (rf2),
    .rf3 (rf3),
    .rf4 (rf4),
    .rf5 (rf5),
    .rf6 (rf6),
    .rf7 (rf7)
  );

  assign rf[0] = rf0;
  assign rf[1] = rf1;
  assign rf[2] = rf2;
  assign rf[3] = rf3;
  assign rf[4] = rf4;
  assign rf[5] = rf5;
  assign rf[6] = rf6;
  assign rf[7] = rf7;

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [5:0] op, input int rd, input int rs,
                                      input int rt, input logic [15:0] imm);
    return {op, 3'(rd), 3'(rs), 3'(rt), 1'b0, imm};
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 8; i++) mregs[i] = '0;
    mpc     = '0;
    mhalted = 1'b0;
  endfunction

  // Instruction-set interpreter: one architectural instruction per call.
  function automatic void model_step();
    logic [31:0] ins, a, b, s, z, ea;
    logic [5:0]  op;
    logic [7:0]  npc;
    int rd, rs, rt;
    if (mhalted) return;
    ins = prog[mpc];
    op  = ins[31:26];
    rd  = int'(ins[25:23]);
    rs  = int'(ins[22:20]);
    rt  = int'(ins[19:17]);
    a   = mregs[rs];
    b   = mregs[rt];
    s   = {{16{ins[15]}}, ins[15:0]};
    z   = {16'h0000, ins[15:0]};
    ea  = a + s;
    npc = mpc + 8'd1;
    case (op)
      6'h01: mregs[rd] = a + b;
      6'h02: mregs[rd] = a - b;
      6'h03: mregs[rd] = a & b;
      6'h04: mregs[rd] = a | b;
      6'h05: mregs[rd] = a ^ b;
      6'h06: mregs[rd] = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'h07: mregs[rd] = a << b[4:0];
      6'h08: mregs[rd] = a >> b[4:0];
`ifdef MUL_EN
      6'h09: mregs[rd] = a * b;
`endif
      6'h10: mregs[rd] = a + s;
      6'h11: mregs[rd] = {ins[15:0], 16'h0000};
      6'h12: mregs[rd] = a | z;
      6'h18: mregs[rd] = mdmem[ea[7:0]];
      6'h19: mdmem[ea[7:0]] = b;
      6'h20: if (a == b) npc = mpc + 8'd1 + s[7:0];
      6'h21: if (a != b) npc = mpc + 8'd1 + s[7:0];
      6'h22: npc = ins[7:0];
      6'h3F: begin mhalted = 1'b1; npc = mpc; end
      default: ;
    endcase
    mpc = npc;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < int'(IDEPTH); i++) prog[i] = '0;
  endtask

  // Loads prog into the ROM and clears RAM while rst is held, then releases reset.
  task automatic start_program();
    rst = 1'b1;
    for (int i = 0; i < int'(IDEPTH); i++) dut.imem[i] = prog[i];
    for (int i = 0; i < int'(DDEPTH); i++) begin
      dut.dmem[i] = '0;
      mdmem[i]    = '0;
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic advance(input int n);
    for (int c = 0; c < n; c++) begin
      model_step();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_alu_prog();
    clear_prog();
    prog[0]  = enc(6'h10, 1, 0, 0, 16'd5);
    prog[1]  = enc(6'h10, 2, 0, 0, 16'hFFFD);
    prog[2]  = enc(6'h01, 3, 1, 2, 16'h0);
    prog[3]  = enc(6'h02, 4, 2, 1, 16'h0);
    prog[4]  = enc(6'h06, 5, 2, 1, 16'h0);
    prog[5]  = enc(6'h11, 1, 0, 0, 16'h1234);
    prog[6]  = enc(6'h12, 1, 1, 0, 16'h5678);
    prog[7]  = enc(6'h10, 6, 0, 0, 16'd1);
    prog[8]  = enc(6'h10, 7, 0, 0, 16'd31);
    prog[9]  = enc(6'h07, 6, 6, 7, 16'h0);
    prog[10] = enc(6'h08, 6, 6, 7, 16'h0);
    prog[11] = enc(6'h3F, 0, 0, 0, 16'h0);
  endtask

  task automatic test_reset();
    load_alu_prog();
    start_program();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rf[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_init rf%0d got %h expected %h", i, rf[i], 32'h0);
      end
    end
    advance(5);
    n_checks++;
    if (rf1 !== 32'd5) begin
      n_fail++;
      $display("FAIL reset_prerun rf1 got %h expected %h", rf1, 32'd5);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if (rf[i] !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_midrun rf%0d got %h expected %h", i, rf[i], 32'h0);
      end
    end
    advance(2);
    n_checks++;
    if (rf1 !== 32'd5 || rf2 !== 32'hFFFFFFFD) begin
      n_fail++;
      $display("FAIL reset_restart rf1/rf2 got %h/%h expected %h/%h", rf1, rf2, 32'd5, 32'hFFFFFFFD);
    end
  endtask

  task automatic test_alu();
    load_alu_prog();
    start_program();
    advance(10);
    n_checks++;
    if (rf6 !== 32'h80000000) begin
      n_fail++;
      $display("FAIL sll_31 rf6 got %h expected %h", rf6, 32'h80000000);
    end
    advance(5);
    n_checks++;
    if (rf3 !== 32'h00000002) begin
      n_fail++;
      $display("FAIL add rf3 got %h expected %h", rf3, 32'h2);
    end
    n_checks++;
    if (rf4 !== 32'hFFFFFFF8) begin
      n_fail++;
      $display("FAIL sub rf4 got %h expected %h", rf4, 32'hFFFFFFF8);
    end
    n_checks++;
    if (rf5 !== 32'h00000001) begin
      n_fail++;
      $display("FAIL slt rf5 got %h expected %h", rf5, 32'h1);
    end
    n_checks++;
    if (rf1 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL lui_ori rf1 got %h expected %h", rf1, 32'h12345678);
    end
    n_checks++;
    if (rf6 !== 32'h00000001) begin
      n_fail++;
      $display("FAIL srl_31 rf6 got %h expected %h", rf6, 32'h1);
    end
  endtask

  task automatic test_memory();
    clear_prog();
    prog[0] = enc(6'h11, 1, 0, 0, 16'h1234);
    prog[1] = enc(6'h12, 1, 1, 0, 16'h5678);
    prog[2] = enc(6'h19, 0, 0, 1, 16'h0010);
    prog[3] = enc(6'h18, 6, 0, 0, 16'h0010);
    prog[4] = enc(6'h10, 2, 0, 0, 16'h0110);
    prog[5] = enc(6'h18, 7, 2, 0, 16'h0000);
    prog[6] = enc(6'h10, 3, 0, 0, 16'h0055);
    prog[7] = enc(6'h19, 0, 2, 3, 16'h0000);
    prog[8] = enc(6'h18, 5, 0, 0, 16'h0010);
    prog[9] = enc(6'h3F, 0, 0, 0, 16'h0);
    start_program();
    advance(12);
    n_checks++;
    if (rf6 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL st_ld rf6 got %h expected %h", rf6, 32'h12345678);
    end
    n_checks++;
    if (rf7 !== 32'h12345678) begin
      n_fail++;
      $display("FAIL ld_alias rf7 got %h expected %h", rf7, 32'h12345678);
    end
    n_checks++;
    if (rf5 !== 32'h00000055) begin
      n_fail++;
      $display("FAIL st_alias rf5 got %h expected %h", rf5, 32'h55);
    end
  endtask

  task automatic test_control_flow();
    clear_prog();
    prog[0]  = enc(6'h10, 1, 0, 0, 16'd10);
    prog[1]  = enc(6'h10, 2, 0, 0, 16'd0);
    prog[2]  = enc(6'h10, 1, 1, 0, 16'hFFFF);
    prog[3]  = enc(6'h10, 2, 2, 0, 16'd1);
    prog[4]  = enc(6'h21, 0, 1, 0, 16'hFFFD);
    prog[5]  = enc(6'h22, 0, 0, 0, 16'd7);
    prog[6]  = enc(6'h10, 3, 0, 0, 16'd99);
    prog[7]  = enc(6'h10, 4, 0, 0, 16'd7);
    prog[8]  = enc(6'h20, 0, 4, 4, 16'd1);
    prog[9]  = enc(6'h10, 5, 0, 0, 16'd1);
    prog[10] = enc(6'h3F, 0, 0, 0, 16'h0);
    prog[11] = enc(6'h10, 7, 0, 0, 16'd1);
    start_program();
    advance(40);
    n_checks++;
    if (rf1 !== 32'd0 || rf2 !== 32'd10) begin
      n_fail++;
      $display("FAIL loop rf1/rf2 got %h/%h expected %h/%h", rf1, rf2, 32'd0, 32'd10);
    end
    n_checks++;
    if (rf3 !== 32'd0 || rf4 !== 32'd7) begin
      n_fail++;
      $display("FAIL jmp rf3/rf4 got %h/%h expected %h/%h", rf3, rf4, 32'd0, 32'd7);
    end
    n_checks++;
    if (rf5 !== 32'd0) begin
      n_fail++;
      $display("FAIL beq_taken rf5 got %h expected %h", rf5, 32'd0);
    end
    for (int c = 0; c < 100; c++) begin
      model_step();
      @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (rf[i] !== mregs[i]) begin
          n_fail++;
          $display("FAIL halt_freeze cycle %0d rf%0d got %h expected %h", c, i, rf[i], mregs[i]);
        end
      end
    end
    n_checks++;
    if (rf7 !== 32'd0 || rf2 !== 32'd10) begin
      n_fail++;
      $display("FAIL halt_final rf7/rf2 got %h/%h expected %h/%h", rf7, rf2, 32'd0, 32'd10);
    end
  endtask

  task automatic test_mul();
    clear_prog();
    prog[0] = enc(6'h11, 1, 0, 0, 16'h0001);
    prog[1] = enc(6'h10, 2, 0, 0, 16'h0077);
    prog[2] = enc(6'h09, 2, 1, 1, 16'h0);
    prog[3] = enc(6'h10, 3, 0, 0, 16'd7);
    prog[4] = enc(6'h10, 4, 0, 0, 16'd6);
    prog[5] = enc(6'h10, 5, 0, 0, 16'h0033);
    prog[6] = enc(6'h09, 5, 3, 4, 16'h0);
    prog[7] = enc(6'h3F, 0, 0, 0, 16'h0);
    start_program();
    advance(10);
`ifdef MUL_EN
    n_checks++;
    if (rf2 !== 32'h00000000) begin
      n_fail++;
      $display("FAIL mul_wrap rf2 got %h expected %h", rf2, 32'h0);
    end
    n_checks++;
    if (rf5 !== 32'h0000002A) begin
      n_fail++;
      $display("FAIL mul_7x6 rf5 got %h expected %h", rf5, 32'h2A);
    end
`else
    n_checks++;
    if (rf2 !== 32'h00000077) begin
      n_fail++;
      $display("FAIL mul_nop rf2 got %h expected %h", rf2, 32'h77);
    end
    n_checks++;
    if (rf5 !== 32'h00000033) begin
      n_fail++;
      $display("FAIL mul_nop rf5 got %h expected %h", rf5, 32'h33);
    end
`endif
  endtask

  task automatic test_random();
    logic [5:0] ops [20] = '{6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
                             6'h08, 6'h09, 6'h10, 6'h11, 6'h12, 6'h18, 6'h19, 6'h20,
                             6'h21, 6'h22, 6'h0A, 6'h2C};
    logic [5:0]  op;
    logic [31:0] r;
    logic [15:0] imm;
    int errs;
    for (int p = 0; p < 4; p++) begin
      clear_prog();
      for (int i = 0; i < 60; i++) begin
        op = ops[$urandom_range(0, 19)];
        r  = $urandom;
        imm = r[15:0];
        if (op == 6'h20 || op == 6'h21) imm = 16'($urandom_range(0, 3));
        if (op == 6'h22) imm = 16'(i + 1 + int'($urandom_range(0, 3)));
        prog[i] = enc(op, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                      int'($urandom_range(0, 7)), imm);
      end
      for (int i = 60; i < 64; i++) prog[i] = enc(6'h3F, 0, 0, 0, 16'h0);
      start_program();
      errs = 0;
      for (int c = 0; c < 70; c++) begin
        model_step();
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
          n_checks++;
          if (rf[i] !== mregs[i]) begin
            n_fail++;
            errs++;
            if (errs <= 8)
              $display("FAIL random prog %0d cycle %0d rf%0d got %h expected %h", p, c, i, rf[i], mregs[i]);
          end
        end
      end
      n_checks++;
      if (mhalted !== 1'b1) begin
        n_fail++;
        $display("FAIL random_halt prog %0d model halted got %b expected %b", p, mhalted, 1'b1);
      end
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_memory();
    test_control_flow();
    test_mul();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
